// File: rtl/fighter_action_sequencer_pkg.sv
// Shared definitions for the fighter action sequencer and the sprite ROM decode:
// state codes, action field layout and the action packing helper.
package fighter_action_sequencer_pkg;

  localparam int unsigned STATE_W       = 3;
  localparam int unsigned STEP_W        = 4;
  localparam int unsigned ACTION_W      = STATE_W + STEP_W;
  localparam int unsigned ACT_STATE_LSB = 4;
  localparam int unsigned ACT_STATE_MSB = 6;
  localparam int unsigned ACT_STEP_LSB  = 0;
  localparam int unsigned ACT_STEP_MSB  = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_WALK  = 3'd1,
    ST_PUNCH = 3'd2,
    ST_KICK  = 3'd3,
    ST_BLOCK = 3'd4,
    ST_STUN  = 3'd5,
    ST_KO    = 3'd6
  } fas_state_e;

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;

  function automatic logic [ACTION_W-1:0] pack_action(input fas_state_e s,
                                                      input logic [STEP_W-1:0] step);
    return {s, step};
  endfunction

endpackage

// File: rtl/fighter_action_sequencer_if.sv
// Control/status bundle between game logic (master) and one fighter sequencer (slave).
interface fighter_action_sequencer_if;
  import fighter_action_sequencer_pkg::*;

  logic                frame_tick;
  logic                round_reset;
  logic                btn_left;
  logic                btn_right;
  logic                btn_punch;
  logic                btn_kick;
  logic                btn_block;
  logic                hit_in;
  logic                ko_in;
  logic [ACTION_W-1:0] action;
  logic [1:0]          move_dir;
  logic                attack_hit;
  logic                blocked_hit;
  logic                busy;

  modport master (
    output frame_tick, round_reset, btn_left, btn_right, btn_punch, btn_kick,
           btn_block, hit_in, ko_in,
    input  action, move_dir, attack_hit, blocked_hit, busy
  );

  modport slave (
    input  frame_tick, round_reset, btn_left, btn_right, btn_punch, btn_kick,
           btn_block, hit_in, ko_in,
    output action, move_dir, attack_hit, blocked_hit, busy
  );

endinterface

// File: rtl/fighter_action_sequencer_anim_step_counter.sv
// Frame-tick divider plus animation step counter; the step wraps to 0 after
// i_last_step, and i_load_zero restarts both divider and step.
module fighter_action_sequencer_anim_step_counter #(
  parameter int unsigned FRAME_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_load_zero,
  input  logic [3:0] i_last_step,
  output logic [3:0] o_step,
  output logic       o_advance,
  output logic       o_last,
  output logic       o_wrap
);

  localparam logic [3:0] DIV_MAX = 4'(FRAME_DIV - 1);

  logic [3:0] r_div;
  logic [3:0] r_step;

  assign o_step    = r_step;
  assign o_advance = i_tick & (r_div == DIV_MAX);
  assign o_last    = (r_step == i_last_step);
  assign o_wrap    = o_advance & o_last;

  // Divider and step registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div  <= 4'd0;
      r_step <= 4'd0;
    end else if (i_load_zero) begin
      r_div  <= 4'd0;
      r_step <= 4'd0;
    end else if (i_tick) begin
      if (r_div == DIV_MAX) begin
        r_div  <= 4'd0;
        r_step <= o_last ? 4'd0 : r_step + 4'd1;
      end else begin
        r_div <= r_div + 4'd1;
      end
    end
  end

endmodule

// File: rtl/fighter_action_sequencer.sv
// Per-player action sequencer: priority FSM evaluated on frame ticks that turns
// buttons and combat events into the sprite action code and hit strobes.
module fighter_action_sequencer
  import fighter_action_sequencer_pkg::*;
#(
  parameter int unsigned FRAME_DIV      = 4,
  parameter int unsigned WALK_STEPS     = 4,
  parameter int unsigned PUNCH_STEPS    = 6,
  parameter int unsigned KICK_STEPS     = 8,
  parameter int unsigned PUNCH_HIT_STEP = 3,
  parameter int unsigned KICK_HIT_STEP  = 5,
  parameter int unsigned STUN_STEPS     = 10
) (
  input logic                        clk,
  input logic                        rst,
  fighter_action_sequencer_if.slave  io_bus
);

  localparam logic [3:0] WALK_LAST  = 4'(WALK_STEPS - 1);
  localparam logic [3:0] PUNCH_LAST = 4'(PUNCH_STEPS - 1);
  localparam logic [3:0] KICK_LAST  = 4'(KICK_STEPS - 1);
  localparam logic [3:0] STUN_LAST  = 4'(STUN_STEPS - 1);
  localparam logic [3:0] PUNCH_HIT  = 4'(PUNCH_HIT_STEP);
  localparam logic [3:0] KICK_HIT   = 4'(KICK_HIT_STEP);

  fas_state_e r_state;
  logic [1:0] r_move_dir;
  logic       r_attack_hit;
  logic       r_blocked_hit;
  logic       r_busy;
  logic       r_hit_latch;

  fas_state_e w_next;
  fas_state_e w_sel;
  logic [1:0] w_dir;
  logic [3:0] w_last_step;
  logic [3:0] w_hit_step;
  logic [3:0] w_step;
  logic       w_advance;
  logic       w_last;
  logic       w_wrap;
  logic       w_load_zero;
  logic       w_cnt_tick;
  logic       w_atk;
  logic       w_blk;
  logic       w_hit;
  logic       w_illegal;

  assign w_hit     = r_hit_latch | io_bus.hit_in;
  assign w_illegal = (3'(r_state) == 3'd7);

  fighter_action_sequencer_anim_step_counter #(
    .FRAME_DIV(FRAME_DIV)
  ) u_anim_step_counter (
    .clk        (clk),
    .rst        (rst),
    .i_tick     (w_cnt_tick),
    .i_load_zero(w_load_zero),
    .i_last_step(w_last_step),
    .o_step     (w_step),
    .o_advance  (w_advance),
    .o_last     (w_last),
    .o_wrap     (w_wrap)
  );

  // Per-state step limits and hit step.
  always_comb begin
    w_last_step = 4'd0;
    w_hit_step  = 4'd0;
    case (r_state)
      ST_WALK:  w_last_step = WALK_LAST;
      ST_PUNCH: begin
        w_last_step = PUNCH_LAST;
        w_hit_step  = PUNCH_HIT;
      end
      ST_KICK:  begin
        w_last_step = KICK_LAST;
        w_hit_step  = KICK_HIT;
      end
      ST_STUN:  w_last_step = STUN_LAST;
      default:  w_last_step = 4'd0;
    endcase
  end

  // Button request: left+right together count as no direction.
  always_comb begin
    if (io_bus.btn_left && !io_bus.btn_right) begin
      w_dir = DIR_LEFT;
    end else if (io_bus.btn_right && !io_bus.btn_left) begin
      w_dir = DIR_RIGHT;
    end else begin
      w_dir = DIR_NONE;
    end
    if (io_bus.btn_punch) begin
      w_sel = ST_PUNCH;
    end else if (io_bus.btn_kick) begin
      w_sel = ST_KICK;
    end else if (io_bus.btn_block) begin
      w_sel = ST_BLOCK;
    end else if (w_dir != DIR_NONE) begin
      w_sel = ST_WALK;
    end else begin
      w_sel = ST_IDLE;
    end
  end

  // Next-state priority decision; only round_reset and illegal codes act off-tick.
  always_comb begin
    w_next      = r_state;
    w_load_zero = 1'b0;
    w_cnt_tick  = 1'b0;
    w_atk       = 1'b0;
    w_blk       = 1'b0;
    if (io_bus.round_reset || w_illegal) begin
      w_next      = ST_IDLE;
      w_load_zero = 1'b1;
    end else if (io_bus.frame_tick) begin
      w_cnt_tick = 1'b1;
      if (io_bus.ko_in || (r_state == ST_KO)) begin
        w_next      = ST_KO;
        w_load_zero = 1'b1;
      end else if (w_hit) begin
        w_load_zero = 1'b1;
        if (r_state == ST_BLOCK) begin
          w_next = ST_BLOCK;
          w_blk  = 1'b1;
        end else begin
          w_next = ST_STUN;
        end
      end else begin
        case (r_state)
          ST_STUN, ST_PUNCH, ST_KICK: begin
            if (w_wrap) begin
              w_next      = ST_IDLE;
              w_load_zero = 1'b1;
            end else begin
              w_next = r_state;
            end
            w_atk = (r_state != ST_STUN) && w_advance && !w_last &&
                    ((w_step + 4'd1) == w_hit_step);
          end
          ST_IDLE, ST_WALK, ST_BLOCK: begin
            w_next      = w_sel;
            w_load_zero = !((w_sel == ST_WALK) && (r_state == ST_WALK));
          end
          default: begin
            w_next      = ST_IDLE;
            w_load_zero = 1'b1;
          end
        endcase
      end
    end else begin
      w_next = r_state;
    end
  end

  // State, registered outputs and hit latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_move_dir    <= DIR_NONE;
      r_attack_hit  <= 1'b0;
      r_blocked_hit <= 1'b0;
      r_busy        <= 1'b0;
      r_hit_latch   <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_attack_hit  <= w_atk;
      r_blocked_hit <= w_blk;
      r_busy        <= (w_next == ST_PUNCH) || (w_next == ST_KICK) ||
                       (w_next == ST_STUN)  || (w_next == ST_KO);
      r_move_dir    <= (w_next != ST_WALK) ? DIR_NONE :
                       (io_bus.frame_tick ? w_dir : r_move_dir);
      r_hit_latch   <= (io_bus.round_reset || io_bus.frame_tick) ? 1'b0 :
                       (r_hit_latch | io_bus.hit_in);
    end
  end

  assign io_bus.action      = pack_action(r_state, w_step);
  assign io_bus.move_dir    = r_move_dir;
  assign io_bus.attack_hit  = r_attack_hit;
  assign io_bus.blocked_hit = r_blocked_hit;
  assign io_bus.busy        = r_busy;

endmodule

// File: doc/fighter_action_sequencer.md
Name: fighter_action_sequencer

Overview:
- Per-player action controller; one instance each for p1 and p2.
- Turns raw button levels and combat events into the 7-bit sprite action code consumed by the sprite ROM / pixel mux.
- Steps animation frames on the VGA frame tick and signals attack hit windows and blocked hits to game logic, which owns health, shield and position.

Parameters:
- FRAME_DIV, 4: frame_ticks per animation step (1..15).
- WALK_STEPS, 4: looping walk cycle length in steps.
- PUNCH_STEPS, 6: punch length in steps.
- KICK_STEPS, 8: kick length in steps.
- PUNCH_HIT_STEP, 3: step index at which punch_hit strobes.
- KICK_HIT_STEP, 5: step index at which kick_hit strobes.
- STUN_STEPS, 10: hitstun length in steps.

Ports:
- clk  in  1  system pixel clock.
- rst  in  1  asynchronous, active-high reset.
- frame_tick  in  1  single-cycle pulse at start of vertical blank.
- round_reset  in  1  synchronous; return to IDLE, clears KO.
- btn_left, btn_right, btn_punch, btn_kick, btn_block  in  1 each  debounced levels.
- hit_in  in  1  single-cycle pulse; opponent attack connected, any cycle.
- ko_in  in  1  level; own health reached 0.
- action  out  7  {state[2:0], step[3:0]} to sprite ROM.
- move_dir  out  2  00 none, 01 left, 10 right; valid in WALK only.
- attack_hit  out  1  single-cycle strobe on hit step.
- blocked_hit  out  1  single-cycle strobe when a hit lands during BLOCK.
- busy  out  1  high in PUNCH, KICK, STUN, KO.

Behaviour:
- Reset: all outputs 0, state IDLE, step 0, divider 0, hit latch 0. Every output is registered.
- State codes: IDLE=0, WALK=1, PUNCH=2, KICK=3, BLOCK=4, STUN=5, KO=6. Code 7 is unused; if reached, force IDLE on the next cycle.
- hit_in latch: set on any cycle; cleared on the frame_tick that consumes it.
- All decisions occur only on cycles with frame_tick=1. Outputs change one cycle after that tick.
- On each tick, the divider increments; on reaching FRAME_DIV-1 it wraps to 0 and the current step advances.
- Entering a new state sets step=0 and divider=0.
- Tick priority, highest first:
  1. ko_in -> KO. KO is sticky; only round_reset or rst leave it.
  2. Latched hit:
     - in BLOCK: stay in BLOCK, pulse blocked_hit.
     - in any other state: go to STUN and abort any attack in progress.
  3. STUN, PUNCH, KICK: run to completion. On the advance past the last step, go to IDLE.
  4. From IDLE, WALK or BLOCK:
     - btn_punch -> PUNCH; btn_kick -> KICK; punch wins if both pressed.
     - else btn_block -> BLOCK.
     - else exactly one of left/right -> WALK with that direction.
     - else IDLE.
- A hit already latched during STUN restarts STUN at step 0.
- WALK: step wraps WALK_STEPS-1 -> 0; a direction change stays in WALK without resetting the step.
- Left and right both pressed: treated as neither (IDLE).
- attack_hit: strobes once, one cycle after the tick on which the step advances to PUNCH_HIT_STEP (PUNCH) or KICK_HIT_STEP (KICK). It never strobes if the attack is aborted first.
- round_reset: synchronous, highest priority; acts immediately without waiting for a tick. Gives IDLE, step 0, and clears the latch.
- rst during an attack: immediate return to the reset values.
- step is 4 bits; all *_STEPS values must be ≤ 16.

Decomposition:
- Shared package: the state code constants (IDLE..KO) and the action field layout (state at [6:4], step at [3:0]). The sprite ROM decode uses the same package.
- One natural sub-module, anim_step_counter: the FRAME_DIV divider plus step counter, with load-zero, advance, last-step and wrap outputs.
- Priority FSM stays in the top.

Test Plan:
- Reset, then 10 ticks with no buttons -> action=7'h00, move_dir=00, busy=0 throughout.
- FRAME_DIV=4, btn_punch held for 1 tick -> action=7'h20 → 7'h21 after 4 ticks; attack_hit exactly one pulse, 12 ticks after entry (step 3); IDLE after 24 ticks; busy high for all 24.
- btn_kick, then hit_in mid-cycle between ticks at step 2 -> next tick action=7'h50; no attack_hit ever; IDLE after 40 ticks.
- btn_block held, hit_in pulsed -> blocked_hit one pulse at the next tick; state stays 4; no STUN.
- btn_right held -> action=7'h10, move_dir=10; step sequence 0,1,2,3,0; then left+right -> 7'h00.
- ko_in asserted during WALK -> 7'h60 on the next tick; buttons ignored; round_reset -> 7'h00 the next cycle without a tick; rst mid-KICK -> all outputs 0 immediately.
